// File: rtl/i2c_master_write_controller.sv
// i2c_master_write_controller: START, address+W, ACK, one data byte, ACK, STOP,
// paced by rising edges of the baud generator's ClockI2C, four ticks per bus bit.
module i2c_master_write_controller (
  input  logic       clock,
  input  logic       Reset,
  input  logic       ClockI2C,
  input  logic       Start,
  input  logic [6:0] Address,
  input  logic [7:0] Data,
  input  logic       SDA_in,
  output logic       BaudEnable,
  output logic       SCL,
  output logic       SDA_out,
  output logic       Busy,
  output logic       Done,
  output logic       AckError
);
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
  state_t     state;
  logic       clk_d;
  logic       tick;
  logic [1:0] phase;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] hold;
  // a level that is already high when the engine is enabled is not an edge
  assign tick = ClockI2C & ~clk_d & BaudEnable;
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state      <= IDLE;
      clk_d      <= 1'b0;
      phase      <= 2'd0;
      bitcnt     <= 3'd0;
      shreg      <= 8'd0;
      hold       <= 8'd0;
      BaudEnable <= 1'b0;
      SCL        <= 1'b1;
      SDA_out    <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      AckError   <= 1'b0;
    end else begin
      clk_d <= ClockI2C;
      Done  <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          shreg      <= {Address, 1'b0};
          hold       <= Data;
          AckError   <= 1'b0;
          Busy       <= 1'b1;
          BaudEnable <= 1'b1;
          phase      <= 2'd0;
          state      <= START;
        end
      end else if (tick) begin
        phase <= phase + 2'd1;
        case (state)
          START: begin
            SCL     <= ~phase[1];
            SDA_out <= phase == 2'd0;
            if (phase == 2'd3) begin
              bitcnt <= 3'd7;
              state  <= ADDR;
            end
          end
          ADDR, DATA: begin
            SCL <= ^phase;
            if (phase == 2'd0) SDA_out <= shreg[7];
            if (phase == 2'd3) begin
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - 3'd1;
              if (bitcnt == 3'd0) state <= state == ADDR ? ACK1 : ACK2;
            end
          end
          ACK1, ACK2: begin
            SCL     <= ^phase;
            SDA_out <= 1'b1;
            if (phase == 2'd2 && SDA_in) AckError <= 1'b1;
            if (phase == 2'd3) begin
              if (state == ACK1 && !AckError) begin
                shreg  <= hold;
                bitcnt <= 3'd7;
                state  <= DATA;
              end else begin
                state <= STOP;
              end
            end
          end
          STOP: begin
            SCL     <= phase != 2'd0;
            SDA_out <= phase[1];
            if (phase == 2'd3) begin
              Busy       <= 1'b0;
              BaudEnable <= 1'b0;
              Done       <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_master_write_controller.md
# i2c_master_write_controller

Byte-level I2C master write engine that sits directly downstream of the I2C baud-rate generator. It consumes the generator's `ClockI2C` output as a phase-tick reference and drives the generator's `Enable` input. It also drives SCL and SDA to issue START, a 7-bit address with W=0, an ACK check, one data byte, a second ACK check and STOP. Everything runs in the system `clock` domain; `ClockI2C` is edge-detected, never used as a clock.

## Interface
- No parameters. Bit timing comes entirely from the upstream generator.
- `clock` input 1: system clock; all logic on its rising edge.
- `Reset` input 1: synchronous, active-low reset.
- `ClockI2C` input 1: generator output; each rising edge is one phase tick.
- `Start` input 1: request a transaction; sampled only in IDLE.
- `Address` input 7: slave address; latched on accepted `Start`.
- `Data` input 8: data byte; latched on accepted `Start`.
- `SDA_in` input 1: sampled bus SDA level, used for ACK.
- `BaudEnable` output 1: drives generator `Enable`; high while busy.
- `SCL` output 1: SCL level (1 = released).
- `SDA_out` output 1: SDA level (0 = drive low, 1 = release).
- `Busy` output 1: transaction in progress.
- `Done` output 1: one-cycle pulse at end of transaction.
- `AckError` output 1: set on NACK; held until next accepted `Start`.

## Operation
- Tick detection:
  - A `ClockI2C_d` register holds the previous `ClockI2C`.
  - `tick = ClockI2C & ~ClockI2C_d`.
  - Ticks are ignored while `BaudEnable`=0.
- Every bus bit occupies 4 ticks, phases 0–3, tracked by a 2-bit phase counter.
  - Data/ACK bit: phase 0 SCL=0 with SDA updated; phase 1 SCL=1; phase 2 SCL=1, SDA_in sampled on entry; phase 3 SCL=0.
- States: IDLE → START → ADDR → ACK1 → DATA → ACK2 → STOP → IDLE.
- IDLE:
  - SCL=1, SDA_out=1, Busy=0, BaudEnable=0.
  - `Start`=1 latches `{Address,1'b0}` into an 8-bit shift register and `Data` into a holding register.
  - It also clears AckError and sets Busy and BaudEnable, then goes to START.
- START (4 ticks): phase 0 SCL=1 SDA=1; phase 1 SCL=1 SDA=0; phases 2–3 SCL=0 SDA=0.
- ADDR / DATA (8 bits each):
  - MSB first.
  - A 3-bit bit counter counts 7 down to 0.
  - The shift register shifts left at phase 3 of each bit.
  - DATA loads the holding register at entry.
- ACK1 / ACK2 (1 bit each):
  - SDA_out=1 for all four phases.
  - `SDA_in` is sampled at phase 2.
  - 0 = ACK: continue.
  - 1 = NACK: set AckError and go to STOP, skipping DATA after an ACK1 NACK.
- STOP (4 ticks): phase 0 SCL=0 SDA=0; phase 1 SCL=1 SDA=0; phases 2–3 SCL=1 SDA=1.
- After phase 3 of STOP: Busy=0, BaudEnable=0, Done=1 for one clock, state IDLE.
- Error path: AckError is set at the sampling tick and stays 1 through Done and IDLE until the next accepted `Start`.

## Timing
- Reset values: SCL=1, SDA_out=1, BaudEnable=0, Busy=0, Done=0, AckError=0, state IDLE, counters 0, `ClockI2C_d`=0.
- All outputs are registered. Each change takes effect on the clock edge of the tick cycle, so it is visible the cycle after the `ClockI2C` rising edge is first seen.
- `Start` accept latency: Busy and BaudEnable are high 1 clock after `Start` is sampled. The first START phase occurs on the first tick after that.
- Tick counts:
  - Full transaction with both ACKs: 4 + 32 + 4 + 32 + 4 + 4 = 80 ticks.
  - NACK at address: 4 + 32 + 4 + 4 = 44 ticks.
- `Start` while Busy is ignored; latched operands do not change.
- `Reset`=0 mid-transaction: on the next edge all outputs return to reset values and no Done is issued. SCL and SDA are released; no STOP is generated.
- A `ClockI2C` that is already high when BaudEnable rises does not produce a tick. Only a 0→1 transition after enable counts.
- `ClockI2C` held constant: the FSM holds its state indefinitely.

## Test plan
- **Reset:** hold Reset=0 for 3 clocks with Start=1 → SCL=1, SDA_out=1, Busy=0, BaudEnable=0, AckError=0 throughout.
- **Nominal write:**
  - Stimulus: Address=7'h50, Data=8'hA5, SDA_in=0 in both ACK slots, ClockI2C pulsing every 6 clocks.
  - Response: SDA bit sequence 1010_0000 then 1010_0101, SCL toggling per phase rules.
  - Done pulses exactly once after 80 ticks; AckError=0.
- **Address NACK:** SDA_in=1 during ACK1 → AckError=1, no DATA bits, STOP follows, Done after 44 ticks.
- **Data NACK:** ACK1=0, ACK2=1 → all 80 ticks run, AckError=1 at Done and still 1 in IDLE. The next Start clears it.
- **Start while Busy:** pulse Start with Address=7'h7F mid-ADDR → transmitted address remains 7'h50 and only one Done is issued.
- **Reset mid-operation:** Reset=0 during DATA bit 3 → next clock SCL=1, SDA_out=1, Busy=0, no Done. A new Start afterwards completes normally.
